// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and shared-RAM signals around the memory arbiter.
// The arbiter attaches through the slave modport; requesters and RAM model use master.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    logic [1:0]        grant;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between an instruction and a data requester.
// Data wins by default; a pending instruction is forced through after STARVE_MAX data grants.
//
// state | meaning
// IDLE  | no owner, sample requests and grant
// IACC  | instruction read in flight on the RAM port
// DACC  | data read/write in flight on the RAM port
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;

    logic d_req;
    logic starved;

    assign d_req   = bus.dREN | bus.dWEN;
    assign starved = (starve_q == STARVE_LIM) & bus.iREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            dren_q   <= dren_d;
            dwen_q   <= dwen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        err_d    = err_q;
        addr_d   = addr_q;
        store_d  = store_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        case (state_q)
            IDLE: begin
                if (starved || (bus.iREN && !d_req)) begin
                    state_d  = IACC;
                    starve_d = '0;
                    addr_d   = bus.iaddr;
                end else if (d_req) begin
                    state_d = DACC;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    dren_d  = bus.dREN;
                    dwen_d  = bus.dWEN;
                    if (bus.iREN && (starve_q != STARVE_LIM))
                        starve_d = starve_q + CNT_W'(1);
                end
            end
            IACC: begin
                if (bus.ramstate == RS_ERROR) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!bus.iREN || (bus.ramstate == RS_ACCESS)) begin
                    state_d = IDLE;
                end
            end
            DACC: begin
                if (bus.ramstate == RS_ERROR) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!d_req || (bus.ramstate == RS_ACCESS)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A dropped request suppresses the completion pulse even if the RAM answers that cycle.
    always_comb begin
        bus.grant    = 2'd0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = addr_q;
        bus.ramstore = store_q;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.err      = err_q;
        case (state_q)
            IACC: begin
                bus.grant  = 2'd1;
                bus.ramREN = 1'b1;
                if ((bus.ramstate == RS_ACCESS) && bus.iREN) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DACC: begin
                bus.grant  = 2'd2;
                bus.ramWEN = dwen_q;
                bus.ramREN = dren_q & ~dwen_q;
                if ((bus.ramstate == RS_ACCESS) && d_req) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32: width of addresses and data words.
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request is pending.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports iREN in 1 (instruction read request) and iaddr in WORD_W (instruction address).
REQ-006 SHALL have ports iwait out 1 and iload out WORD_W: iwait=0 for one cycle marks instruction completion, with iload valid in that cycle.
REQ-007 SHALL have ports dREN in 1, dWEN in 1, daddr in WORD_W, dstore in WORD_W: data read or write request.
REQ-008 SHALL have ports dwait out 1 and dload out WORD_W: dwait=0 for one cycle marks data completion, with dload valid on reads.
REQ-009 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out WORD_W, ramstore out WORD_W: the shared RAM request.
REQ-010 SHALL have ports ramload in WORD_W (RAM read data) and ramstate in 2 (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-011 SHALL have port grant out 2 (0 none, 1 instruction, 2 data) and port err out 1 (sticky RAM-error flag).

Function
REQ-012 SHALL implement FSM states IDLE, IACC, DACC in a state register.
REQ-013 IDLE SHALL go to DACC if dREN|dWEN, else to IACC if iREN, else stay IDLE.
REQ-014 Exception to REQ-013: if starve_cnt==STARVE_MAX and iREN, IDLE SHALL go to IACC even with a data request pending.
REQ-015 starve_cnt SHALL increment on each IDLE->DACC taken while iREN=1, saturating at STARVE_MAX.
REQ-016 starve_cnt SHALL clear on any IDLE->IACC.
REQ-017 On grant, address and store data SHALL be latched into registers; ramaddr/ramstore SHALL drive the latched values, stable for the whole transaction.
REQ-018 In IACC: ramREN=1, ramWEN=0, grant=1.
REQ-019 In DACC: ramREN=latched dREN and ramWEN=latched dWEN; if both were set, ramWEN wins and ramREN=0; grant=2.
REQ-020 In IDLE: ramREN=ramWEN=0 and grant=0.
REQ-021 In IACC/DACC with ramstate==ACCESS, the owning wait SHALL be 0 in that same cycle, load SHALL equal ramload (combinational), and the next state SHALL be IDLE.
REQ-022 Minimum transaction is one grant cycle; every completion is followed by one IDLE cycle before the next grant.
REQ-023 While ramstate is FREE or BUSY, the FSM SHALL hold state and keep the owning wait=1.
REQ-024 If the owner drops its request mid-transaction (for DACC, both dREN and dWEN low), the FSM SHALL return to IDLE next cycle with no completion pulse and RAM enables deasserted from that cycle.
REQ-025 ramstate==ERROR SHALL set err=1, return the FSM to IDLE with no completion pulse, and leave the requester waiting for a retry.
REQ-026 The non-owning wait SHALL always be 1; iwait and dwait SHALL never be 0 in the same cycle.
REQ-027 iload/dload SHALL read 0 when their wait is 1.
REQ-028 The request inputs SHALL be sampled only in IDLE; changes in the request data during a transaction SHALL be ignored (latched values apply), except request drop per REQ-024.

Reset
REQ-029 nRST low SHALL asynchronously force: state IDLE, starve_cnt 0, err 0, latched address/store 0.
REQ-030 During and after reset until the first grant: iwait=dwait=1, ramREN=ramWEN=0, grant=0, loads 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no completion pulse; the first grant after release follows REQ-013.

Verification
REQ-032 Instruction read: iREN=1, iaddr=0x100, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> grant=1 for 3 cycles, iwait=0 and iload=0xDEADBEEF in the 3rd, then IDLE.
REQ-033 Simultaneous requests: iREN=1, dWEN=1, daddr=0x200, dstore=0x1234 -> data first (ramWEN=1, ramaddr=0x200), dwait pulse, one IDLE cycle, then IACC.
REQ-034 Starvation: iREN held and 5 back-to-back data requests, STARVE_MAX=4 -> 4 DACC grants, then an IACC grant before the 5th data grant, after which starve_cnt=0.
REQ-035 RAM error: ramstate=ERROR during DACC -> err=1 (sticky), no dwait pulse, next cycle IDLE; retry completes normally with err still 1.
REQ-036 Abort/reset: dREN dropped mid-DACC -> IDLE next cycle with no pulse; nRST pulsed mid-IACC -> all outputs at reset values immediately.
